pc_fetch_stage: RTL



---
 rtl/pc_fetch_if.sv | 36 +++
 rtl/pc_fetch_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-stage signal bundle: hazard/branch/halt controls, instruction memory, IF/ID latch.
// The PC_ALIGN_CHECK_EN macro adds the sticky misalign flag.
interface pc_fetch_if;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        halt_i;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        flush_o;
  logic        halted_o;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  // Fetch stage side.
  modport master (
    input  stall_i, branch_taken_i, branch_target_i, halt_i, instr_i,
    output pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, flush_o, halted_o
`ifdef PC_ALIGN_CHECK_EN
    , output misalign_o
`endif
  );

  // Pipeline / memory side.
  modport slave (
    output stall_i, branch_taken_i, branch_target_i, halt_i, instr_i,
    input  pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, flush_o, halted_o
`ifdef PC_ALIGN_CHECK_EN
    , input misalign_o
`endif
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID latch, branch redirect/squash and halt.
// Optional PC_ALIGN_CHECK_EN forces branch targets word-aligned and flags misalignment.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input logic         clk,
  input logic         rst,
  pc_fetch_if.master  bus
);

  typedef enum logic [1:0] {StRun, StRedir, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        halted_q, halted_d;
  logic        flush_c;
  logic [31:0] target_c;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_q, misalign_d;
  assign target_c = {bus.branch_target_i[31:2], 2'b00};
`else
  assign target_c = bus.branch_target_i;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    halted_d      = halted_q;
    flush_c       = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d    = misalign_q;
`endif
    unique case (state_q)
      StRun: begin
        if (bus.branch_taken_i) begin
          pc_d          = target_c;
          if_id_valid_d = 1'b0;
          if_id_instr_d = 32'h0;
          flush_c       = 1'b1;
          state_d       = StRedir;
`ifdef PC_ALIGN_CHECK_EN
          if (bus.branch_target_i[1:0] != 2'b00) misalign_d = 1'b1;
`endif
        end else if (bus.stall_i) begin
          // hold everything
        end else if (bus.halt_i) begin
          if_id_valid_d = 1'b0;
          halted_d      = 1'b1;
          state_d       = StHalt;
        end else begin
          pc_d          = pc_q + 32'(PC_STEP);
          if_id_pc_d    = pc_q;
          if_id_instr_d = bus.instr_i;
          if_id_valid_d = 1'b1;
        end
      end
      // Branch/halt here come from the squashed wrong-path instruction.
      StRedir: begin
        if (!bus.stall_i) begin
          pc_d          = pc_q + 32'(PC_STEP);
          if_id_pc_d    = pc_q;
          if_id_instr_d = bus.instr_i;
          if_id_valid_d = 1'b1;
          state_d       = StRun;
        end
      end
      StHalt: begin
        if_id_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      halted_q      <= halted_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.if_id_pc_o    = if_id_pc_q;
  assign bus.if_id_instr_o = if_id_instr_q;
  assign bus.if_id_valid_o = if_id_valid_q;
  assign bus.halted_o      = halted_q;
  assign bus.flush_o       = flush_c & ~rst;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.misalign_o    = misalign_q;
`endif

endmodule
